// File: rtl/popcount22_weight_gen.sv
// Enumerates every N-bit vector of a requested Hamming weight in ascending
// order, one pattern per accepted handshake, using the Gosper successor.
module popcount22_weight_gen #(
  parameter int N  = 22,
  parameter int WW = 5,
  parameter int IW = 20
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [WW-1:0] weight_i,
  output logic          busy_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [N-1:0]  out_vec_o,
  output logic [IW-1:0] out_idx_o,
  output logic          out_last_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N:0] ONE = (N + 1)'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [N-1:0]  lastVec_q, lastVec_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [N:0]    xWide, cLow, rSum, lowMask;
  logic [CW-1:0] ctz;
  logic [31:0]   weightWide, shiftAmt;
  logic          isLast;

  // Successor math is one bit wider than the vector so r = x + c never wraps.
  always_comb begin
    xWide      = {1'b0, vec_q};
    cLow       = xWide & (~xWide + ONE);
    rSum       = xWide + cLow;
    ctz        = '0;
    for (int i = N; i >= 0; i--) begin
      if (xWide[i]) ctz = CW'(i);
    end
    weightWide = {{(32 - WW){1'b0}}, weight_i};
    shiftAmt   = 32'(N) - weightWide;
    lowMask    = (ONE << weight_i) - ONE;
    isLast     = (vec_q == lastVec_q);
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    idx_d     = idx_q;
    lastVec_d = lastVec_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (weightWide > 32'(N)) begin
            err_d = 1'b1;
          end else begin
            state_d   = RUN;
            vec_d     = N'(lowMask);
            idx_d     = '0;
            lastVec_d = N'(lowMask << shiftAmt);
          end
        end
      end
      RUN: begin
        if (out_ready_i) begin
          if (isLast) begin
            state_d = IDLE;
            done_d  = 1'b1;
            vec_d   = '0;
            idx_d   = '0;
          end else begin
            vec_d = N'((((rSum ^ xWide) >> 2) >> ctz) | rSum);
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      idx_q     <= '0;
      lastVec_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      idx_q     <= idx_d;
      lastVec_q <= lastVec_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy_o      = (state_q == RUN);
  assign out_valid_o = (state_q == RUN);
  assign out_last_o  = (state_q == RUN) && isLast;
  assign out_vec_o   = vec_q;
  assign out_idx_o   = idx_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
